// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: critical-word-first AHB-Lite WRAP burst refill sequencer for an I-cache line
module icache_refill_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                          hclk,
  input  logic                          hrstn,
  input  logic                          miss_req,
  input  logic [ADDR_W-1:0]             miss_addr,
  output logic                          miss_ack,
  output logic                          fill_we,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [DATA_W-1:0]             fill_data,
  output logic                          fill_done,
  output logic                          fill_err,
  output logic [ADDR_W-1:0]             haddr,
  output logic [1:0]                    htrans,
  output logic [2:0]                    hburst,
  output logic [2:0]                    hsize,
  output logic                          hwrite,
  output logic [3:0]                    hprot,
  input  logic                          hready,
  input  logic                          hresp,
  input  logic [DATA_W-1:0]             hrdata
);
  localparam int IW = $clog2(LINE_WORDS);
  localparam int BW = ADDR_W - IW - 2;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] WRAP = (LINE_WORDS == 4) ? 3'b010 : (LINE_WORDS == 8) ? 3'b100 : 3'b110;

  if (!(LINE_WORDS == 4 || LINE_WORDS == 8 || LINE_WORDS == 16)) begin : g_bad_line
    $error("icache_refill_ctrl: LINE_WORDS must be 4, 8 or 16");
  end

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_DRAIN, S_ERR} state_t;
  state_t state, state_nx;

  logic [BW-1:0] line_base;
  logic [IW-1:0] start_idx, beat, d_idx, cur_idx, nxt_idx;
  logic          d_valid, last, err, cap;
  logic          unused_ok;

  assign hsize     = 3'b010;
  assign hwrite    = 1'b0;
  assign hprot     = 4'b0010;
  assign unused_ok = ^miss_addr[1:0];

  // next state, acceptance and beat bookkeeping; an error with hready already high skips ERR
  always_comb begin
    miss_ack = miss_req & (state == S_IDLE);
    cur_idx  = start_idx + beat;
    nxt_idx  = cur_idx + IW'(1);
    last     = &beat;
    err      = d_valid & hresp;
    cap      = d_valid & hready & ~hresp;
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = miss_req ? S_ADDR : S_IDLE;
      S_ADDR:  state_nx = err ? (hready ? S_IDLE : S_ERR) : hready ? S_BURST : S_ADDR;
      S_BURST: state_nx = err ? (hready ? S_IDLE : S_ERR) : (hready && last) ? S_DRAIN : S_BURST;
      S_DRAIN: state_nx = err ? (hready ? S_IDLE : S_ERR) : hready ? S_IDLE : S_DRAIN;
      S_ERR:   state_nx = hready ? S_IDLE : S_ERR;
      default: state_nx = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) state <= S_IDLE;
    else        state <= state_nx;
  end

  // bus address/control pipeline and fill-port registers; bus side only moves on hready
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      line_base <= '0;
      start_idx <= '0;
      beat      <= '0;
      d_idx     <= '0;
      d_valid   <= 1'b0;
      haddr     <= '0;
      htrans    <= T_IDLE;
      hburst    <= 3'b000;
      fill_we   <= 1'b0;
      fill_idx  <= '0;
      fill_data <= '0;
      fill_done <= 1'b0;
      fill_err  <= 1'b0;
    end else begin
      fill_we   <= cap;
      fill_done <= cap & (state == S_DRAIN);
      fill_err  <= 1'b0;
      if (cap) begin
        fill_idx  <= d_idx;
        fill_data <= hrdata;
      end
      if (miss_ack) begin
        line_base <= miss_addr[ADDR_W-1:IW+2];
        start_idx <= miss_addr[IW+1:2];
        beat      <= '0;
        haddr     <= {miss_addr[ADDR_W-1:2], 2'b00};
        htrans    <= T_NSEQ;
        hburst    <= WRAP;
      end else if (err) begin
        htrans   <= T_IDLE;
        d_valid  <= 1'b0;
        fill_err <= hready;
      end else if (state == S_ERR) begin
        fill_err <= hready;
      end else if (hready && (state == S_ADDR || state == S_BURST)) begin
        d_valid <= 1'b1;
        d_idx   <= cur_idx;
        beat    <= beat + IW'(1);
        htrans  <= (state == S_BURST && last) ? T_IDLE : T_SEQ;
        haddr   <= (state == S_BURST && last) ? haddr : {line_base, nxt_idx, 2'b00};
      end else if (hready && state == S_DRAIN) begin
        d_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: scoreboard bench for the refill controller at LINE_WORDS 4 and 8
module tb_icache_refill_ctrl;
  typedef struct {int idx; logic [31:0] data; bit last;} exp_t;

  logic hclk = 1'b0, hrstn = 1'b0;
  int   cyc = 0, n_chk = 0, n_pass = 0, unexp = 0;
  int   done4 = 0, err4 = 0, done_cyc4 = 0, done8 = 0, done_cyc8 = 0;
  exp_t q4[$], q8[$];
  exp_t e4, e8;

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  logic        miss_req, miss_ack, fill_we, fill_done, fill_err, hwrite, hready, hresp;
  logic [31:0] miss_addr, fill_data, haddr, hrdata;
  logic [1:0]  fill_idx, htrans;
  logic [2:0]  hburst, hsize;
  logic [3:0]  hprot;

  logic        miss_req8, miss_ack8, fill_we8, fill_done8, fill_err8, hwrite8, hready8, hresp8;
  logic [31:0] miss_addr8, fill_data8, haddr8, hrdata8;
  logic [2:0]  fill_idx8, hburst8, hsize8;
  logic [1:0]  htrans8;
  logic [3:0]  hprot8;

  icache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) u_dut4 (
    .hclk(hclk), .hrstn(hrstn), .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data), .fill_done(fill_done),
    .fill_err(fill_err), .haddr(haddr), .htrans(htrans), .hburst(hburst), .hsize(hsize),
    .hwrite(hwrite), .hprot(hprot), .hready(hready), .hresp(hresp), .hrdata(hrdata));

  icache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(8)) u_dut8 (
    .hclk(hclk), .hrstn(hrstn), .miss_req(miss_req8), .miss_addr(miss_addr8), .miss_ack(miss_ack8),
    .fill_we(fill_we8), .fill_idx(fill_idx8), .fill_data(fill_data8), .fill_done(fill_done8),
    .fill_err(fill_err8), .haddr(haddr8), .htrans(htrans8), .hburst(hburst8), .hsize(hsize8),
    .hwrite(hwrite8), .hprot(hprot8), .hready(hready8), .hresp(hresp8), .hrdata(hrdata8));

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5EED_C0DE;
  endfunction

  // AHB slave models: data phase follows an accepted non-IDLE address phase
  logic        dp4, dp8;
  logic [31:0] dpa4, dpa8;
  always @(posedge hclk or negedge hrstn)
    if (!hrstn) begin dp4 <= 1'b0; dpa4 <= '0; end
    else if (hready) begin dp4 <= htrans[1]; dpa4 <= haddr; end
  always @(posedge hclk or negedge hrstn)
    if (!hrstn) begin dp8 <= 1'b0; dpa8 <= '0; end
    else if (hready8) begin dp8 <= htrans8[1]; dpa8 <= haddr8; end
  assign hrdata  = dp4 ? word_of(dpa4) : 32'h0;
  assign hrdata8 = dp8 ? word_of(dpa8) : 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic void push_line(input logic [31:0] a, input int lw, input int n, input bit to8);
    logic [31:0] base;
    int s;
    exp_t e;
    base = a & ~(32'(lw * 4) - 32'd1);
    s = int'((a >> 2) % 32'(lw));
    for (int k = 0; k < n; k++) begin
      e.idx  = (s + k) % lw;
      e.data = word_of(base + 32'(e.idx * 4));
      e.last = (k == lw - 1);
      if (to8) q8.push_back(e); else q4.push_back(e);
    end
  endfunction

  always @(negedge hclk) if (hrstn) begin
    if (fill_done) begin done4++; done_cyc4 = cyc; end
    if (fill_err) err4++;
    if (fill_we) begin
      if (q4.size() == 0) unexp++;
      else begin
        e4 = q4.pop_front();
        check("idx4", 64'(fill_idx), 64'(e4.idx));
        check("data4", 64'(fill_data), 64'(e4.data));
        check("done4", 64'(fill_done), 64'(e4.last));
      end
    end
  end

  always @(negedge hclk) if (hrstn) begin
    if (fill_done8) begin done8++; done_cyc8 = cyc; end
    if (fill_we8) begin
      if (q8.size() == 0) unexp++;
      else begin
        e8 = q8.pop_front();
        check("idx8", 64'(fill_idx8), 64'(e8.idx));
        check("data8", 64'(fill_data8), 64'(e8.data));
        check("done8", 64'(fill_done8), 64'(e8.last));
      end
    end
  end

  task automatic miss4(input logic [31:0] a, input int n, output int t);
    @(negedge hclk);
    miss_req = 1'b1;
    miss_addr = a;
    #1;
    for (int i = 0; i < 20 && !miss_ack; i++) begin @(negedge hclk); #1; end
    check("ack4", 64'(miss_ack), 64'd1);
    t = cyc;
    push_line(a, 4, n, 1'b0);
  endtask

  task automatic wait_end4(input int bd, input int be);
    for (int i = 0; i < 60 && done4 == bd && err4 == be; i++) @(negedge hclk);
    check("end4_seen", 64'(done4 != bd || err4 != be), 64'd1);
  endtask

  logic [31:0] ta[4];
  int t, t2, bd, be;

  initial begin
    miss_req = 0; miss_addr = 0; hready = 1; hresp = 0;
    miss_req8 = 0; miss_addr8 = 0; hready8 = 1; hresp8 = 0;
    repeat (3) @(negedge hclk);
    check("rst_htrans", 64'(htrans), 64'd0);
    check("rst_haddr", 64'(haddr), 64'd0);
    check("rst_hburst", 64'(hburst), 64'd0);
    check("rst_fill_we", 64'(fill_we), 64'd0);
    check("rst_fill_done", 64'(fill_done), 64'd0);
    check("rst_fill_err", 64'(fill_err), 64'd0);
    check("rst_fill_idx", 64'(fill_idx), 64'd0);
    check("rst_fill_data", 64'(fill_data), 64'd0);
    check("hsize", 64'(hsize), 64'd2);
    check("hwrite", 64'(hwrite), 64'd0);
    check("hprot", 64'(hprot), 64'd2);
    hrstn = 1;

    // zero-wait critical-word-first line
    ta = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
    bd = done4; be = err4;
    miss4(32'h0000_1008, 4, t);
    @(negedge hclk); miss_req = 0; #1;
    check("zw_haddr0", 64'(haddr), 64'(ta[0]));
    check("zw_htrans0", 64'(htrans), 64'd2);
    check("zw_hburst", 64'(hburst), 64'd2);
    for (int k = 1; k < 4; k++) begin
      @(negedge hclk); #1;
      check("zw_haddr", 64'(haddr), 64'(ta[k]));
      check("zw_htrans", 64'(htrans), 64'd3);
    end
    @(negedge hclk); #1;
    check("zw_htrans_idle", 64'(htrans), 64'd0);
    wait_end4(bd, be);
    check("zw_done_lat", 64'(done_cyc4 - t), 64'd6);

    // three wait states on the data phase of beat 1
    bd = done4; be = err4;
    miss4(32'h0000_3004, 4, t);
    @(negedge hclk); miss_req = 0;
    @(negedge hclk);
    @(negedge hclk); hready = 0; #1;
    check("ws_haddr", 64'(haddr), 64'h300C);
    for (int k = 0; k < 2; k++) begin
      @(negedge hclk); #1;
      check("ws_haddr_hold", 64'(haddr), 64'h300C);
      check("ws_htrans_hold", 64'(htrans), 64'd3);
      check("ws_no_we", 64'(fill_we), 64'd0);
    end
    @(negedge hclk); hready = 1; #1;
    check("ws_no_we", 64'(fill_we), 64'd0);
    wait_end4(bd, be);
    check("ws_done_lat", 64'(done_cyc4 - t), 64'd9);

    // ERROR response on beat 2
    bd = done4; be = err4;
    miss4(32'h0000_4008, 2, t);
    @(negedge hclk); miss_req = 0;
    @(negedge hclk);
    @(negedge hclk);
    @(negedge hclk); hready = 0; hresp = 1;
    @(negedge hclk); hready = 1; hresp = 1; #1;
    check("err_htrans_idle", 64'(htrans), 64'd0);
    @(negedge hclk); hresp = 0; #1;
    check("err_pulse", 64'(fill_err), 64'd1);
    @(negedge hclk); #1;
    check("err_pulse_end", 64'(fill_err), 64'd0);
    repeat (5) @(negedge hclk);
    check("err_count", 64'(err4 - be), 64'd1);
    check("err_no_done", 64'(done4 - bd), 64'd0);
    check("err_q_empty", 64'(q4.size()), 64'd0);

    // back-to-back misses
    bd = done4; be = err4;
    miss4(32'h0000_5004, 4, t);
    @(negedge hclk); miss_addr = 32'h0000_600C; #1;
    for (int i = 0; i < 20 && !miss_ack; i++) begin @(negedge hclk); #1; end
    t2 = cyc;
    check("b2b_ack", 64'(miss_ack), 64'd1);
    check("b2b_ack_cyc", 64'(t2 - t), 64'd6);
    check("b2b_done_same", 64'(fill_done), 64'd1);
    push_line(32'h0000_600C, 4, 4, 1'b0);
    bd = done4;
    @(negedge hclk); miss_req = 0; #1;
    check("b2b_nonseq", 64'(htrans), 64'd2);
    check("b2b_haddr", 64'(haddr), 64'h600C);
    wait_end4(bd, be);
    check("b2b_done_lat", 64'(done_cyc4 - t2), 64'd6);

    // reset in the middle of a burst
    bd = done4; be = err4;
    miss4(32'h0000_7000, 4, t);
    @(negedge hclk); miss_req = 0;
    repeat (3) @(negedge hclk);
    #2 hrstn = 0; #1;
    check("mrst_htrans", 64'(htrans), 64'd0);
    check("mrst_haddr", 64'(haddr), 64'd0);
    check("mrst_fill_we", 64'(fill_we), 64'd0);
    check("mrst_fill_done", 64'(fill_done), 64'd0);
    check("mrst_fill_err", 64'(fill_err), 64'd0);
    q4.delete();
    repeat (2) @(negedge hclk);
    #2 hrstn = 1;
    repeat (10) @(negedge hclk);
    check("mrst_no_done", 64'(done4 - bd), 64'd0);
    check("mrst_no_err", 64'(err4 - be), 64'd0);

    // LINE_WORDS=8 wrap from the last word
    @(negedge hclk); miss_req8 = 1; miss_addr8 = 32'h2000_001C; #1;
    for (int i = 0; i < 20 && !miss_ack8; i++) begin @(negedge hclk); #1; end
    check("ack8", 64'(miss_ack8), 64'd1);
    t = cyc;
    push_line(32'h2000_001C, 8, 8, 1'b1);
    @(negedge hclk); miss_req8 = 0; #1;
    check("w8_hburst", 64'(hburst8), 64'd4);
    check("w8_htrans0", 64'(htrans8), 64'd2);
    check("w8_haddr0", 64'(haddr8), 64'h2000_001C);
    repeat (7) @(negedge hclk); #1;
    check("w8_haddr_last", 64'(haddr8), 64'h2000_0018);
    check("w8_htrans_last", 64'(htrans8), 64'd3);
    for (int i = 0; i < 40 && done8 == 0; i++) @(negedge hclk);
    check("w8_done_count", 64'(done8), 64'd1);
    check("w8_done_lat", 64'(done_cyc8 - t), 64'd10);

    repeat (3) @(negedge hclk);
    check("unexpected_we", 64'(unexp), 64'd0);
    check("q4_drained", 64'(q4.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
